spike_collision_fsm: RTL and testbench
======================================

Name: spike_collision_fsm

Overview:
- Sits directly downstream of the spike array. It consumes the per-pixel spike descriptor (is_spike_1, direction, tile-local address) together with the ball-pixel flag.
- During each raster frame it detects pixel-exact overlap between the ball and the opaque triangle of any spike.
- At each frame tick it runs the life/death FSM. Its output death gates spike traps and ball motion.
- death convention: 1 = play active, 0 = dead/frozen.

Parameters:
TILE, 20, spike tile edge in pixels; local coordinate = address mod TILE
H_VIS, 640, visible width; pixels with DrawX >= H_VIS are ignored
V_VIS, 480, visible height; pixels with DrawY >= V_VIS are ignored
DYING_FRAMES, 30, frames spent in DYING before DEAD
FLASH_FRAMES, 4, frames per half-period of death_flash
RESPAWN_FRAMES, 120, frames in DEAD before auto-respawn (only with AUTO_RESPAWN_EN)

Ports:
Clk  in  1  system clock; the only clock
Reset_h  in  1  synchronous, active-high reset
key_R  in  1  restart key, level, synchronous to Clk
VGA_VS  in  1  vertical sync; its rising edge, detected in the Clk domain, is the frame tick
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
is_ball  in  1  current pixel belongs to the ball
is_spike_1  in  1  current pixel lies inside a spike bounding box
Spike_Direct_1  in  2  spike direction: 0 Up, 1 Right, 2 Down, 3 Left
Spike_X_Addr_1  in  10  X offset inside the spike box
Spike_Y_Addr_1  in  10  Y offset inside the spike box
death  out  1  1 in PLAY, 0 otherwise
death_flash  out  1  blink enable for the ball renderer while DYING
hit_pixel  out  1  registered: previous pixel was an opaque spike-and-ball overlap
death_count  out  8  death counter, saturates at 255

Behaviour:
- Reset (Reset_h=1 on a Clk edge): state=PLAY, death=1, death_flash=0, hit_pixel=0, death_count=0, hit_latch=0, frame counter=0, VGA_VS history register=1.
- Frame tick: vs_q is VGA_VS registered once. tick = VGA_VS & ~vs_q, a one-Clk pulse.
- Mask stage (combinational):
  - u = Spike_X_Addr_1 mod TILE, v = Spike_Y_Addr_1 mod TILE.
  - du = |2u-19|, dv = |2v-19|.
  - Opaque: Up: v+1 >= du. Down: 20-v >= du. Left: u+1 >= dv. Right: 20-u >= dv.
- Pixel stage, registered with 1-Clk latency: hit_pixel <= is_ball & is_spike_1 & opaque & DrawX<H_VIS & DrawY<V_VIS.
- hit_latch:
  - Sets on hit_pixel=1.
  - Clears on tick.
  - If set and clear happen in the same cycle, clear wins, and a set arriving in that cycle is carried into the new frame.
  - hit_latch is held at 0 outside PLAY.
- FSM, advancing only on tick unless noted:
  - PLAY: if hit_latch → DYING, frame counter=0, death_count+1 (saturating). Otherwise stay in PLAY.
  - DYING: frame counter+1. When the counter reaches DYING_FRAMES-1 → DEAD, counter=0.
  - DEAD: wait. Leaves only via key_R, or via auto-respawn when compiled in.
  - RESPAWN: on the next tick → PLAY. Lasts exactly one frame so that upstream spikes finish resetting before play resumes.
- key_R=1 on any Clk edge in any state → RESPAWN, counter=0, hit_latch=0. death_count is not cleared; only Reset_h clears it.
- Priority: Reset_h > key_R > tick transitions.
- death_flash = counter[bit] toggling every FLASH_FRAMES ticks in DYING. It is 0 in all other states.
- death is a registered decode of state and is updated in the same cycle as the state change.
- Reset mid-frame discards any latched hit.

Optional Feature:
AUTO_RESPAWN_EN
- Defined: DEAD counts ticks and moves to RESPAWN when the counter reaches RESPAWN_FRAMES-1. key_R still works.
- Undefined: DEAD persists until key_R or Reset_h, and RESPAWN_FRAMES is unused.

Decomposition:
- Shared package spike_pkg:
  - spike_dir_t enum (UP=0, RIGHT=1, DOWN=2, LEFT=3)
  - life_state_t enum (PLAY, DYING, DEAD, RESPAWN)
  - constants SCREEN_W=640, SCREEN_H=480, SPIKE_TILE=20
- Sub-module spike_tri_mask: purely combinational. Takes direction, X/Y address and TILE, and outputs opaque. It is reused by the renderer.

Test Plan:
- Ball pixel at Up spike, local (u=9,v=0), is_spike_1=1 → hit_pixel=1 one Clk later. At (u=0,v=0) → hit_pixel=0.
- Hit in frame N → on the next tick, state=DYING, death=0, death_count=1. After 30 further ticks, state=DEAD.
- In DEAD, pulse key_R for 1 Clk → RESPAWN with death=0. After one tick → PLAY, death=1, death_count still 1.
- Hit at DrawX=645, or is_ball=0 with an opaque spike → no transition, death stays 1.
- Assert Reset_h during DYING at frame 10 → next Clk: PLAY, death=1, death_count=0, death_flash=0.
- 256 forced deaths → death_count holds at 255. With AUTO_RESPAWN_EN, DEAD → RESPAWN after 120 ticks with no key.

Source files
------------

// File: rtl/spike_pkg.sv
// Shared types and screen/tile constants for the spike collision path and the spike renderer.
package spike_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } spike_dir_t;

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        DYING   = 2'd1,
        DEAD    = 2'd2,
        RESPAWN = 2'd3
    } life_state_t;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int SPIKE_TILE = 20;

    function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/spike_tri_mask.sv
// Combinational opaque-triangle test for one spike tile pixel; shared with the renderer.
module spike_tri_mask
    import spike_pkg::*;
#(
    parameter int TILE = SPIKE_TILE
) (
    input  logic [1:0] direct_i,
    input  logic [9:0] x_addr_i,
    input  logic [9:0] y_addr_i,
    output logic       opaque_o
);

    localparam logic [10:0] TL  = 11'(TILE);
    localparam logic [10:0] TM1 = 11'(TILE - 1);

    logic [10:0] u;
    logic [10:0] v;
    logic [10:0] du;
    logic [10:0] dv;

    assign u  = 11'(x_addr_i % 10'(TILE));
    assign v  = 11'(y_addr_i % 10'(TILE));
    // Distance from the tile centre line, doubled to stay integer for even TILE.
    assign du = abs_diff({u[9:0], 1'b0}, TM1);
    assign dv = abs_diff({v[9:0], 1'b0}, TM1);

    always_comb begin
        opaque_o = 1'b0;
        case (spike_dir_t'(direct_i))
            UP:      opaque_o = (v + 11'd1) >= du;
            DOWN:    opaque_o = (TL - v) >= du;
            LEFT:    opaque_o = (u + 11'd1) >= dv;
            RIGHT:   opaque_o = (TL - u) >= dv;
            default: opaque_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/spike_collision_fsm.sv
// Ball/spike pixel collision detector and per-frame life/death FSM (death=1 means play active).
// Optional AUTO_RESPAWN_EN: DEAD returns to RESPAWN by itself after RESPAWN_FRAMES ticks.
module spike_collision_fsm
    import spike_pkg::*;
#(
    parameter int TILE           = SPIKE_TILE,
    parameter int H_VIS          = SCREEN_W,
    parameter int V_VIS          = SCREEN_H,
    parameter int DYING_FRAMES   = 30,
    parameter int FLASH_FRAMES   = 4,
    parameter int RESPAWN_FRAMES = 120
) (
    input  logic       Clk,
    input  logic       Reset_h,
    input  logic       key_R,
    input  logic       VGA_VS,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       is_ball,
    input  logic       is_spike_1,
    input  logic [1:0] Spike_Direct_1,
    input  logic [9:0] Spike_X_Addr_1,
    input  logic [9:0] Spike_Y_Addr_1,
    output logic       death,
    output logic       death_flash,
    output logic       hit_pixel,
    output logic [7:0] death_count
);

    localparam int CNT_MAX   = (RESPAWN_FRAMES > DYING_FRAMES) ? RESPAWN_FRAMES : DYING_FRAMES;
    localparam int CNT_W     = (CNT_MAX > 8) ? $clog2(CNT_MAX) : 4;
    localparam int FLASH_BIT = $clog2(FLASH_FRAMES);

    life_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       dcount_q, dcount_d;
    logic             latch_q, latch_d;
    logic             hit_q, hit_d;
    logic             vs_q;
    logic             death_q, death_d;
    logic             flash_q, flash_d;
    logic             tick;
    logic             opaque;

    spike_tri_mask #(.TILE(TILE)) u_mask (
        .direct_i (Spike_Direct_1),
        .x_addr_i (Spike_X_Addr_1),
        .y_addr_i (Spike_Y_Addr_1),
        .opaque_o (opaque)
    );

    assign tick  = VGA_VS & ~vs_q;
    assign hit_d = is_ball & is_spike_1 & opaque
                 & (DrawX < 10'(H_VIS)) & (DrawY < 10'(V_VIS));

    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state_q  <= PLAY;
            cnt_q    <= '0;
            dcount_q <= '0;
            latch_q  <= 1'b0;
            hit_q    <= 1'b0;
            vs_q     <= 1'b1;
            death_q  <= 1'b1;
            flash_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dcount_q <= dcount_d;
            latch_q  <= latch_d;
            hit_q    <= hit_d;
            vs_q     <= VGA_VS;
            death_q  <= death_d;
            flash_q  <= flash_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dcount_d = dcount_q;
        if (key_R) begin
            state_d = RESPAWN;
            cnt_d   = '0;
        end else if (tick) begin
            case (state_q)
                PLAY: begin
                    if (latch_q) begin
                        state_d  = DYING;
                        cnt_d    = '0;
                        dcount_d = (dcount_q == 8'hFF) ? dcount_q : dcount_q + 8'd1;
                    end
                end
                DYING: begin
                    if (cnt_q == CNT_W'(DYING_FRAMES - 1)) begin
                        state_d = DEAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DEAD: begin
`ifdef AUTO_RESPAWN_EN
                    if (cnt_q == CNT_W'(RESPAWN_FRAMES - 1)) begin
                        state_d = RESPAWN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    state_d = DEAD;
`endif
                end
                RESPAWN: begin
                    state_d = PLAY;
                    cnt_d   = '0;
                end
                default: state_d = PLAY;
            endcase
        end

        // A hit arriving on the tick cycle belongs to the frame that just started.
        if (state_d != PLAY) begin
            latch_d = 1'b0;
        end else if (tick) begin
            latch_d = hit_q;
        end else begin
            latch_d = latch_q | hit_q;
        end
    end

    always_comb begin
        death_d = (state_d == PLAY);
        flash_d = (state_d == DYING) & cnt_d[FLASH_BIT];
    end

    assign death       = death_q;
    assign death_flash = flash_q;
    assign hit_pixel   = hit_q;
    assign death_count = dcount_q;

endmodule

// File: tb/tb_spike_collision_fsm.sv
// Directed bench: mask/gating vector table plus hand-written FSM sequences.
module tb_spike_collision_fsm;
    import spike_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_h = 1'b1;
    logic       key_R = 1'b0;
    logic       VGA_VS = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic       is_ball = 1'b0;
    logic       is_spike_1 = 1'b0;
    logic [1:0] Spike_Direct_1 = '0;
    logic [9:0] Spike_X_Addr_1 = '0;
    logic [9:0] Spike_Y_Addr_1 = '0;
    logic       death;
    logic       death_flash;
    logic       hit_pixel;
    logic [7:0] death_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    spike_collision_fsm dut (
        .Clk            (Clk),
        .Reset_h        (Reset_h),
        .key_R          (key_R),
        .VGA_VS         (VGA_VS),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .is_ball        (is_ball),
        .is_spike_1     (is_spike_1),
        .Spike_Direct_1 (Spike_Direct_1),
        .Spike_X_Addr_1 (Spike_X_Addr_1),
        .Spike_Y_Addr_1 (Spike_Y_Addr_1),
        .death          (death),
        .death_flash    (death_flash),
        .hit_pixel      (hit_pixel),
        .death_count    (death_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0] dir;
        int         xa;
        int         ya;
        logic       ball;
        logic       spike;
        int         dx;
        int         dy;
        logic       exp_hit;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        VGA_VS = 1'b1;
        step();
        VGA_VS = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_pix(input logic [1:0] d, input int xa, input int ya,
                             input logic b, input logic s, input int dx, input int dy);
        Spike_Direct_1 = d;
        Spike_X_Addr_1 = 10'(xa);
        Spike_Y_Addr_1 = 10'(ya);
        is_ball        = b;
        is_spike_1     = s;
        DrawX          = 10'(dx);
        DrawY          = 10'(dy);
    endtask

    // One opaque overlap pixel, then idle pixel so the latch captures it.
    task automatic do_hit();
        drive_pix(2'd0, 9, 0, 1'b1, 1'b1, 100, 100);
        step();
        is_ball = 1'b0;
        step();
    endtask

    task automatic key_pulse();
        key_R = 1'b1;
        step();
        key_R = 1'b0;
    endtask

    function automatic int sat_inc(input int c);
        return (c >= 255) ? 255 : c + 1;
    endfunction

    initial begin
        // dir, xa, ya, ball, spike, DrawX, DrawY, expected hit
        vecs.push_back('{2'd0,  9,  0, 1, 1, 100, 100, 1});
        vecs.push_back('{2'd0,  0,  0, 1, 1, 100, 100, 0});
        vecs.push_back('{2'd0, 29, 20, 1, 1, 100, 100, 1});
        vecs.push_back('{2'd0,  0, 19, 1, 1, 100, 100, 1});
        vecs.push_back('{2'd0,  5,  5, 1, 1, 100, 100, 0});
        vecs.push_back('{2'd0,  5,  8, 1, 1, 100, 100, 1});
        vecs.push_back('{2'd2,  9, 19, 1, 1, 100, 100, 1});
        vecs.push_back('{2'd2,  0, 19, 1, 1, 100, 100, 0});
        vecs.push_back('{2'd2,  0,  0, 1, 1, 100, 100, 1});
        vecs.push_back('{2'd3,  0,  9, 1, 1, 100, 100, 1});
        vecs.push_back('{2'd3,  0,  0, 1, 1, 100, 100, 0});
        vecs.push_back('{2'd3, 19,  0, 1, 1, 100, 100, 1});
        vecs.push_back('{2'd1, 19, 10, 1, 1, 100, 100, 1});
        vecs.push_back('{2'd1, 19,  0, 1, 1, 100, 100, 0});
        vecs.push_back('{2'd1,  0,  0, 1, 1, 100, 100, 1});
        vecs.push_back('{2'd0,  9,  0, 1, 1, 645, 100, 0});
        vecs.push_back('{2'd0,  9,  0, 1, 1, 100, 480, 0});
        vecs.push_back('{2'd0,  9,  0, 1, 1, 639, 479, 1});
        vecs.push_back('{2'd0,  9,  0, 0, 1, 100, 100, 0});
        vecs.push_back('{2'd0,  9,  0, 1, 0, 100, 100, 0});

        step();
        step();
        chk("rst_death", death, 1);
        chk("rst_flash", death_flash, 0);
        chk("rst_hit", hit_pixel, 0);
        chk("rst_count", death_count, 0);
        chk("rst_state", int'(dut.state_q), int'(PLAY));
        Reset_h = 1'b0;
        step();

        foreach (vecs[i]) begin
            drive_pix(vecs[i].dir, vecs[i].xa, vecs[i].ya, vecs[i].ball,
                      vecs[i].spike, vecs[i].dx, vecs[i].dy);
            step();
            chk($sformatf("mask_vec%0d", i), hit_pixel, vecs[i].exp_hit);
        end
        is_ball = 1'b0;
        step();
        chk("hit_clears", hit_pixel, 0);

        // Latched hits from the table must be discarded by reset.
        Reset_h = 1'b1;
        step();
        Reset_h = 1'b0;
        step();
        tick();
        chk("rst_discard_death", death, 1);

        // Death sequence.
        do_hit();
        chk("pre_tick_death", death, 1);
        tick();
        exp_cnt = sat_inc(exp_cnt);
        chk("dying_state", int'(dut.state_q), int'(DYING));
        chk("dying_death", death, 0);
        chk("dying_count", death_count, exp_cnt);
        chk("flash_f0", death_flash, 0);
        ticks(3);
        chk("flash_f3", death_flash, 0);
        tick();
        chk("flash_f4", death_flash, 1);
        ticks(3);
        chk("flash_f7", death_flash, 1);
        tick();
        chk("flash_f8", death_flash, 0);
        ticks(21);
        chk("dying_f29_state", int'(dut.state_q), int'(DYING));
        tick();
        chk("dead_state", int'(dut.state_q), int'(DEAD));
        chk("dead_death", death, 0);
        chk("dead_flash", death_flash, 0);
        tick();
        chk("dead_holds", int'(dut.state_q), int'(DEAD));

        key_pulse();
        chk("respawn_state", int'(dut.state_q), int'(RESPAWN));
        chk("respawn_death", death, 0);
        step();
        step();
        chk("respawn_holds", int'(dut.state_q), int'(RESPAWN));
        tick();
        chk("play_state", int'(dut.state_q), int'(PLAY));
        chk("play_death", death, 1);
        chk("play_count_kept", death_count, exp_cnt);

        // Overlaps that must not kill: off-screen and non-ball pixels.
        drive_pix(2'd0, 9, 0, 1'b1, 1'b1, 645, 100);
        step();
        is_ball = 1'b0;
        step();
        tick();
        chk("offscreen_death", death, 1);
        drive_pix(2'd0, 9, 0, 1'b0, 1'b1, 100, 100);
        step();
        step();
        tick();
        chk("noball_death", death, 1);

        // Reset in the middle of DYING.
        do_hit();
        tick();
        exp_cnt = sat_inc(exp_cnt);
        ticks(10);
        chk("dying10_death", death, 0);
        Reset_h = 1'b1;
        step();
        Reset_h = 1'b0;
        exp_cnt = 0;
        chk("mid_rst_state", int'(dut.state_q), int'(PLAY));
        chk("mid_rst_death", death, 1);
        chk("mid_rst_count", death_count, 0);
        chk("mid_rst_flash", death_flash, 0);
        step();

        // key_R beats a simultaneous tick.
        do_hit();
        tick();
        exp_cnt = sat_inc(exp_cnt);
        key_R  = 1'b1;
        VGA_VS = 1'b1;
        step();
        key_R  = 1'b0;
        VGA_VS = 1'b0;
        step();
        chk("key_vs_tick", int'(dut.state_q), int'(RESPAWN));
        tick();
        chk("key_vs_tick_play", death, 1);
        chk("key_vs_tick_count", death_count, exp_cnt);

        // Hit coinciding with the tick is carried into the next frame.
        drive_pix(2'd0, 9, 0, 1'b1, 1'b1, 100, 100);
        step();
        is_ball = 1'b0;
        VGA_VS  = 1'b1;
        step();
        chk("carry_same_tick", death, 1);
        VGA_VS = 1'b0;
        step();
        tick();
        exp_cnt = sat_inc(exp_cnt);
        chk("carry_next_tick", death, 0);
        chk("carry_count", death_count, exp_cnt);
        key_pulse();
        tick();

        // Saturation of the death counter.
        for (int i = 0; i < 256; i++) begin
            do_hit();
            tick();
            exp_cnt = sat_inc(exp_cnt);
            chk($sformatf("sat_count%0d", i), death_count, exp_cnt);
            key_pulse();
            tick();
        end
        chk("sat_final", death_count, 255);
        chk("sat_play", death, 1);

        // DEAD dwell.
        do_hit();
        tick();
        ticks(30);
        chk("dwell_dead", int'(dut.state_q), int'(DEAD));
`ifdef AUTO_RESPAWN_EN
        ticks(119);
        chk("auto_f119", int'(dut.state_q), int'(DEAD));
        tick();
        chk("auto_respawn", int'(dut.state_q), int'(RESPAWN));
        tick();
        chk("auto_play", death, 1);
`else
        ticks(130);
        chk("no_auto_dead", int'(dut.state_q), int'(DEAD));
        chk("no_auto_death", death, 0);
`endif
        chk("final_count", death_count, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
